output_interface: RTL and testbench
===================================

OUTPUT_INTERFACE -- requirements
Module: output_interface

Interface
REQ-001 The block SHALL have parameter NBytes, default 1024, giving the vector length in bytes (addressed 0..NBytes-1).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 100, giving the UART bit period in clk cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port command, input, 4 bits: the instruction code, a one-cycle pulse; 0 means idle.
REQ-006 The block SHALL have port vec_ready, input, 2 bits: bit1 = vector A loaded, bit0 = vector B loaded.
REQ-007 The block SHALL have port bram_addr, output, 10 bits: the shared read address for BRAM_A and BRAM_B.
REQ-008 The block SHALL have port bramA_data, input, 8 bits: BRAM_A read data, valid 1 cycle after the address.
REQ-009 The block SHALL have port bramB_data, input, 8 bits: BRAM_B read data, valid 1 cycle after the address.
REQ-010 The block SHALL have port uart_tx, output, 1 bit: the serial transmit line, idle high.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a command is complete.

Function
REQ-012 Command codes SHALL be: 2 = echo A, 3 = echo B, 4 = element sum A+B, 5 = dot product A·B.
REQ-013 A command pulse SHALL be accepted only in IDLE; pulses arriving in any other state SHALL be ignored.
REQ-014 The FSM SHALL have states IDLE, CHECK, ADDR, FETCH, LOAD, SEND, WAIT_TX, FINISH.
REQ-015 Transitions:
- IDLE -> CHECK on command != 0; the code is latched.
- CHECK -> ADDR if the operands are ready; on error -> LOAD with the error byte.
- ADDR -> FETCH (address driven).
- FETCH -> LOAD, or for dot: FETCH -> ADDR (next address) or LOAD (after the last address).
- LOAD -> SEND -> WAIT_TX.
- WAIT_TX -> ADDR (more elements), LOAD (more dot bytes) or FINISH.
- FINISH -> IDLE.
REQ-016 Operand readiness SHALL be: echo A needs vec_ready[1]; echo B needs vec_ready[0]; sum and dot need both bits.
REQ-017 The ready check SHALL be evaluated once, in CHECK.
REQ-018 An unknown code (1, 6..15) or unready operands SHALL transmit the single byte 8'hEE, then pulse done.
REQ-019 Echo SHALL transmit NBytes bytes, address 0 first.
REQ-020 Sum SHALL transmit NBytes bytes, each (A[i]+B[i]) mod 256.
REQ-021 Dot SHALL accumulate the unsigned 8x8 products into a 32-bit accumulator without overflow.
REQ-022 Dot SHALL then transmit the 4 accumulator bytes, MSB first, after all NBytes products are accumulated.
REQ-023 The address SHALL increment by 1 per element and stop at NBytes-1; it SHALL never wrap within a command.
REQ-024 bram_addr SHALL read 0 in IDLE.
REQ-025 The BRAM read latency SHALL be exactly 1 cycle; data SHALL be sampled in FETCH.
REQ-026 The UART handshake SHALL be: tx_start pulses 1 cycle in SEND with the byte held stable.
REQ-027 The next byte SHALL not start until the tx_done pulse arrives in WAIT_TX.
REQ-028 done SHALL pulse for exactly 1 cycle, in FINISH, one cycle after the tx_done of the final byte.
REQ-029 Each byte on uart_tx SHALL be 8N1, LSB first, with the line held high between frames.

Reset
REQ-030 While reset = 0, the block SHALL asynchronously force state = IDLE, bram_addr = 0, done = 0, uart_tx = 1, accumulator = 0 and the latched command = 0.
REQ-031 A reset mid-transmission SHALL abort the frame immediately, leaving uart_tx high and no done pulse.
REQ-032 After reset, the first clk edge SHALL already accept a command.

Structure
REQ-033 A shared package accel_pkg SHALL hold the command-code constants, the FSM state enum, the ERR_BYTE constant (8'hEE) and the 32-bit accumulator typedef.
REQ-034 The single sub-module SHALL be uart_tx (parameter CLKS_PER_BIT; ports Clock, reset, Tx_Start, Tx_Byte, Tx_Serial, Tx_Done).
REQ-035 The uart_tx sub-module SHALL be instantiated once.

Verification
REQ-036 Bench SHALL cover: NBytes = 4, A = {1,2,3,4}, vec_ready = 2'b10, command 2 -> serial bytes 01 02 03 04, then one done pulse.
REQ-037 Bench SHALL cover: A = {FF,01,80,00}, B = {01,01,80,05}, vec_ready = 2'b11, command 4 -> bytes 00 02 00 05.
REQ-038 Bench SHALL cover: A = {FF,FF,FF,FF}, B = {FF,FF,FF,FF}, command 5 -> bytes 00 03 F8 04 (0x0003F804), then done.
REQ-039 Bench SHALL cover: vec_ready = 2'b01 with command 2, and separately command 9 -> a single byte EE, then done.
REQ-040 Bench SHALL cover: a second command pulse during a transmission -> ignored, output unchanged.
REQ-041 Bench SHALL cover: reset = 0 during the 2nd byte -> uart_tx = 1 immediately, no done, and the next command starts cleanly.

Source files
------------

// File: rtl/accel_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the vector accelerator output path: command codes,
// the output FSM state encoding, the error byte, the dot-product accumulator
// type and two small helpers used by output_interface.
// ---------------------------------------------------------------------------
package accel_pkg;

    // Instruction codes arriving on the command port (0 means no command)
    localparam logic [3:0] CMD_NONE   = 4'd0;
    localparam logic [3:0] CMD_ECHO_A = 4'd2;
    localparam logic [3:0] CMD_ECHO_B = 4'd3;
    localparam logic [3:0] CMD_SUM    = 4'd4;
    localparam logic [3:0] CMD_DOT    = 4'd5;

    // Byte sent back for unknown codes or missing operands
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    // Dot-product accumulator; 1024 products of 8x8 bits fit without overflow
    typedef logic [31:0] acc_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADDR,
        FETCH,
        LOAD,
        SEND,
        WAIT_TX,
        FINISH
    } state_t;

    // True when the code is a known command and all of its operands are loaded.
    // vec_ready bit1 = vector A, bit0 = vector B.
    function automatic logic cmd_ready(input logic [3:0] code, input logic [1:0] ready);
        logic ok;
        ok = 1'b0;
        case (code)
            CMD_ECHO_A: ok = ready[1];
            CMD_ECHO_B: ok = ready[0];
            CMD_SUM:    ok = ready[1] & ready[0];
            CMD_DOT:    ok = ready[1] & ready[0];
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Picks accumulator byte idx, idx 0 being the most significant byte
    function automatic logic [7:0] acc_byte(input acc_t acc, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0:    b = acc[31:24];
            2'd1:    b = acc[23:16];
            2'd2:    b = acc[15:8];
            default: b = acc[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter, LSB first, line idle high.
// Ports:
//   Clock     - system clock, rising edge
//   reset     - asynchronous active-low reset; forces the line high at once
//   Tx_Start  - one-cycle request, Tx_Byte sampled on the same edge
//   Tx_Byte   - byte to send
//   Tx_Serial - serial output line
//   Tx_Done   - one-cycle pulse at the end of the stop bit
// Each bit lasts exactly CLKS_PER_BIT clock cycles.
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Byte,
    output logic       Tx_Serial,
    output logic       Tx_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t     tx_state;
    logic [CW-1:0] clk_count;
    logic [2:0]    bit_index;
    logic [7:0]    shift_reg;

    // Frame sequencer. The line is driven straight from registers so it never
    // glitches; the start bit goes out on the same edge that accepts Tx_Start,
    // and each following bit is loaded when the previous one has lasted a full
    // bit period. The data byte is shifted right so bit 0 is always next.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            tx_state  <= TX_IDLE;
            clk_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            Tx_Serial <= 1'b1;
            Tx_Done   <= 1'b0;
        end else begin
            Tx_Done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    Tx_Serial <= 1'b1;
                    clk_count <= '0;
                    bit_index <= '0;
                    if (Tx_Start) begin
                        shift_reg <= Tx_Byte;
                        Tx_Serial <= 1'b0;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count <= '0;
                        Tx_Serial <= shift_reg[0];
                        tx_state  <= TX_DATA;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count <= '0;
                        if (bit_index == 3'd7) begin
                            Tx_Serial <= 1'b1;
                            tx_state  <= TX_STOP;
                        end else begin
                            bit_index <= bit_index + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            Tx_Serial <= shift_reg[1];
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count <= '0;
                        Tx_Done   <= 1'b1;
                        tx_state  <= TX_IDLE;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                default: begin
                    tx_state  <= TX_IDLE;
                    Tx_Serial <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/output_interface.sv
// ---------------------------------------------------------------------------
// output_interface
// Executes one command at a time over the two operand BRAMs and streams the
// result out over a UART.
//   2 = echo A, 3 = echo B, 4 = element sum (A+B mod 256),
//   5 = dot product (32-bit, 4 bytes MSB first).
// Unknown codes or missing operands send the single byte ERR_BYTE.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   command    - one-cycle instruction pulse, accepted only in IDLE
//   vec_ready  - bit1 = vector A loaded, bit0 = vector B loaded
//   bram_addr  - shared read address for both BRAMs (0 while idle)
//   bramA_data - BRAM_A data, one cycle after the address
//   bramB_data - BRAM_B data, one cycle after the address
//   uart_tx    - serial output, idle high
//   done       - one-cycle pulse when a command has finished
// ---------------------------------------------------------------------------
module output_interface
    import accel_pkg::*;
#(
    parameter int NBytes       = 1024,
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] command,
    input  logic [1:0] vec_ready,
    output logic [9:0] bram_addr,
    input  logic [7:0] bramA_data,
    input  logic [7:0] bramB_data,
    output logic       uart_tx,
    output logic       done
);

    localparam logic [9:0] LAST_ADDR = 10'(NBytes - 1);

    state_t     state;
    logic [3:0] cmd_q;
    logic       err_q;
    acc_t       acc;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [1:0] byte_idx;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_done;

    // Command sequencer. The address register is the element counter: it is
    // held during ADDR/FETCH so the BRAM sees a stable address for its one
    // cycle of latency, and only advances once the element has been consumed
    // (after its byte is sent, or after its product is accumulated for dot).
    // The readiness decision is frozen into err_q in CHECK so later changes
    // on vec_ready cannot affect a running command. tx_start and done are
    // registered so they are high for exactly the SEND and FINISH cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= CMD_NONE;
            err_q     <= 1'b0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            byte_idx  <= '0;
            tx_byte   <= '0;
            tx_start  <= 1'b0;
            bram_addr <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bram_addr <= '0;
                    done      <= 1'b0;
                    if (command != CMD_NONE) begin
                        cmd_q <= command;
                        err_q <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    acc      <= '0;
                    byte_idx <= '0;
                    if (cmd_ready(cmd_q, vec_ready)) begin
                        state <= ADDR;
                    end else begin
                        err_q <= 1'b1;
                        state <= LOAD;
                    end
                end
                ADDR: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (cmd_q == CMD_DOT) begin
                        acc <= acc + (acc_t'(bramA_data) * acc_t'(bramB_data));
                        if (bram_addr == LAST_ADDR) begin
                            state <= LOAD;
                        end else begin
                            bram_addr <= bram_addr + 1'b1;
                            state     <= ADDR;
                        end
                    end else begin
                        a_q   <= bramA_data;
                        b_q   <= bramB_data;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (err_q) begin
                        tx_byte <= ERR_BYTE;
                    end else begin
                        case (cmd_q)
                            CMD_ECHO_A: tx_byte <= a_q;
                            CMD_ECHO_B: tx_byte <= b_q;
                            CMD_SUM:    tx_byte <= a_q + b_q;
                            CMD_DOT:    tx_byte <= acc_byte(acc, byte_idx);
                            default:    tx_byte <= ERR_BYTE;
                        endcase
                    end
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (err_q) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else if (cmd_q == CMD_DOT) begin
                            if (byte_idx == 2'd3) begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                state    <= LOAD;
                            end
                        end else if (bram_addr == LAST_ADDR) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            bram_addr <= bram_addr + 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                FINISH: begin
                    done      <= 1'b0;
                    bram_addr <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .Clock    (clk),
        .reset    (reset),
        .Tx_Start (tx_start),
        .Tx_Byte  (tx_byte),
        .Tx_Serial(uart_tx),
        .Tx_Done  (tx_done)
    );

endmodule

// File: tb/tb_output_interface.sv
// ---------------------------------------------------------------------------
// tb_output_interface
// Directed bench for output_interface with NBytes = 4 and a short bit period.
// A BRAM model answers reads one cycle after the address, a serial receiver
// decodes uart_tx into a byte queue, and done pulses are counted.
// ---------------------------------------------------------------------------
module tb_output_interface;

    localparam int NB  = 4;
    localparam int CPB = 8;

    logic       clk;
    logic       reset;
    logic [3:0] command;
    logic [1:0] vec_ready;
    logic [9:0] bram_addr;
    logic [7:0] bramA_data;
    logic [7:0] bramB_data;
    logic       uart_tx;
    logic       done;

    logic [7:0] memA [NB];
    logic [7:0] memB [NB];
    logic [7:0] rx_q [$];
    int         done_count;
    int         vec_count;
    int         miscompare_count;

    output_interface #(
        .NBytes      (NB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .command   (command),
        .vec_ready (vec_ready),
        .bram_addr (bram_addr),
        .bramA_data(bramA_data),
        .bramB_data(bramB_data),
        .uart_tx   (uart_tx),
        .done      (done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model with one cycle of read latency
    always @(posedge clk) begin
        if (bram_addr < 10'd4) begin
            bramA_data <= memA[bram_addr[1:0]];
            bramB_data <= memB[bram_addr[1:0]];
        end else begin
            bramA_data <= 8'h00;
            bramB_data <= 8'h00;
        end
    end

    // Count done pulses away from the active edge
    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    // Serial receiver: centre-samples each bit, keeps frames with a good stop bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (uart_tx === 1'b1) rx_q.push_back(b);
            end
        end
    end

    // Counts one comparison and reports it if it misses
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Pulses a command for one clock cycle
    task automatic applyStimulus(input logic [3:0] cmd);
        @(negedge clk);
        command = cmd;
        @(negedge clk);
        command = 4'd0;
    endtask

    // Waits (bounded) for one new done pulse, then checks nothing extra follows
    task automatic waitDone(input string tag, input int start_count);
        int n;
        n = 0;
        while (done_count == start_count && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        checkOutput({tag, "_done_pulses"}, 32'(done_count - start_count), 32'd1);
        checkOutput({tag, "_addr_idle"}, 32'(bram_addr), 32'd0);
    endtask

    // Compares the received bytes against n expected bytes, first byte in the MSBs
    task automatic checkBytes(input string tag, input int n, input logic [31:0] exp_word);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        checkOutput({tag, "_byte_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            exp_b = exp_word[8*(n-1-i) +: 8];
            got_b = (i < rx_q.size()) ? rx_q[i] : 8'hXX;
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got_b), 32'(exp_b));
        end
        rx_q.delete();
    endtask

    initial begin
        int start;
        int n;
        vec_count        = 0;
        miscompare_count = 0;
        done_count       = 0;
        command          = 4'd0;
        vec_ready        = 2'b00;
        reset            = 1'b0;
        for (int i = 0; i < NB; i++) begin
            memA[i] = 8'h00;
            memB[i] = 8'h00;
        end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_addr", 32'(bram_addr), 32'd0);
        reset = 1'b1;

        // Echo A
        memA[0] = 8'h01; memA[1] = 8'h02; memA[2] = 8'h03; memA[3] = 8'h04;
        vec_ready = 2'b10;
        start = done_count;
        applyStimulus(4'd2);
        waitDone("echoA", start);
        checkBytes("echoA", 4, 32'h01020304);

        // Element sum with wraparound
        memA[0] = 8'hFF; memA[1] = 8'h01; memA[2] = 8'h80; memA[3] = 8'h00;
        memB[0] = 8'h01; memB[1] = 8'h01; memB[2] = 8'h80; memB[3] = 8'h05;
        vec_ready = 2'b11;
        start = done_count;
        applyStimulus(4'd4);
        waitDone("sum", start);
        checkBytes("sum", 4, 32'h00020005);

        // Dot product at maximum operand values
        for (int i = 0; i < NB; i++) begin
            memA[i] = 8'hFF;
            memB[i] = 8'hFF;
        end
        start = done_count;
        applyStimulus(4'd5);
        waitDone("dot", start);
        checkBytes("dot", 4, 32'h0003F804);

        // Echo A with only B loaded -> error byte
        vec_ready = 2'b01;
        start = done_count;
        applyStimulus(4'd2);
        waitDone("notready", start);
        checkBytes("notready", 1, 32'h000000EE);

        // Unknown code -> error byte
        vec_ready = 2'b11;
        start = done_count;
        applyStimulus(4'd9);
        waitDone("badcode", start);
        checkBytes("badcode", 1, 32'h000000EE);

        // A second command during transmission is ignored
        memA[0] = 8'h01; memA[1] = 8'h02; memA[2] = 8'h03; memA[3] = 8'h04;
        vec_ready = 2'b10;
        start = done_count;
        applyStimulus(4'd2);
        repeat (100) @(negedge clk);
        applyStimulus(4'd4);
        waitDone("ignore", start);
        repeat (200) @(negedge clk);
        checkOutput("ignore_no_extra_done", 32'(done_count - start), 32'd1);
        checkBytes("ignore", 4, 32'h01020304);

        // Reset during the second byte aborts cleanly
        start = done_count;
        applyStimulus(4'd2);
        n = 0;
        while (rx_q.size() < 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (uart_tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_in_byte2_start", 32'(uart_tx), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_uart_tx_high", 32'(uart_tx), 32'd1);
        checkOutput("abort_addr", 32'(bram_addr), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("abort_line_held", 32'(uart_tx), 32'd1);
        reset = 1'b1;
        repeat (150) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_count - start), 32'd0);
        rx_q.delete();

        // Next command after the abort runs normally
        start = done_count;
        applyStimulus(4'd2);
        waitDone("after_reset", start);
        checkBytes("after_reset", 4, 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
